// File: rtl/sda_gmem_pkg.sv
// Shared response/burst codes, FSM encodings and the log2 helper for the gmem slave RAM.
package sda_gmem_pkg;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    typedef enum logic       {RD_IDLE, RD_DATA}           rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP}  wr_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction
endpackage

// File: rtl/sda_gmem_burst_addr.sv
// Per-channel burst tracker: holds the word index, beats remaining and legality of one burst.
module sda_gmem_burst_addr #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_index,
    input  logic [7:0]       i_len,
    input  logic             i_legal,
    input  logic             i_step,
    output logic [IDX_W-1:0] o_index,
    output logic [IDX_W-1:0] o_next_index,
    output logic [7:0]       o_remaining,
    output logic             o_last,
    output logic             o_legal
);
    logic [IDX_W-1:0] r_index;
    logic [7:0]       r_remaining;
    logic             r_legal;

    // Index wraps naturally at the RAM depth; no 4 KB boundary handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index     <= '0;
            r_remaining <= '0;
            r_legal     <= 1'b0;
        end else if (i_start) begin
            r_index     <= i_index;
            r_remaining <= i_len;
            r_legal     <= i_legal;
        end else if (i_step) begin
            r_index     <= r_index + IDX_W'(1);
            r_remaining <= r_remaining - 8'd1;
        end
    end

    assign o_index      = r_index;
    assign o_next_index = r_index + IDX_W'(1);
    assign o_remaining  = r_remaining;
    assign o_last       = (r_remaining == 8'd0);
    assign o_legal      = r_legal;
endmodule

// File: rtl/sda_gmem_slave_ram.sv
// AXI4 slave RAM responder for a kernel's m_axi_gmem port: independent read/write FSMs, INCR bursts.
// Define SDA_GMEM_SLAVE_STALL_EN to add LFSR-driven random back-pressure.
module sda_gmem_slave_ram
    import sda_gmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int USER_WIDTH     = 1,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   i_s_axi_gmem_awaddr,
    input  logic [7:0]              i_s_axi_gmem_awlen,
    input  logic [2:0]              i_s_axi_gmem_awsize,
    input  logic [1:0]              i_s_axi_gmem_awburst,
    input  logic [ID_WIDTH-1:0]     i_s_axi_gmem_awid,
    input  logic [USER_WIDTH-1:0]   i_s_axi_gmem_awuser,
    input  logic                    i_s_axi_gmem_awlock,
    input  logic [3:0]              i_s_axi_gmem_awcache,
    input  logic [2:0]              i_s_axi_gmem_awprot,
    input  logic [3:0]              i_s_axi_gmem_awqos,
    input  logic [3:0]              i_s_axi_gmem_awregion,
    input  logic                    i_s_axi_gmem_awvalid,
    output logic                    o_s_axi_gmem_awready,
    input  logic [DATA_WIDTH-1:0]   i_s_axi_gmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_s_axi_gmem_wstrb,
    input  logic                    i_s_axi_gmem_wlast,
    input  logic [USER_WIDTH-1:0]   i_s_axi_gmem_wuser,
    input  logic                    i_s_axi_gmem_wvalid,
    output logic                    o_s_axi_gmem_wready,
    output logic [1:0]              o_s_axi_gmem_bresp,
    output logic [ID_WIDTH-1:0]     o_s_axi_gmem_bid,
    output logic [USER_WIDTH-1:0]   o_s_axi_gmem_buser,
    output logic                    o_s_axi_gmem_bvalid,
    input  logic                    i_s_axi_gmem_bready,
    input  logic [ADDR_WIDTH-1:0]   i_s_axi_gmem_araddr,
    input  logic [7:0]              i_s_axi_gmem_arlen,
    input  logic [2:0]              i_s_axi_gmem_arsize,
    input  logic [1:0]              i_s_axi_gmem_arburst,
    input  logic [ID_WIDTH-1:0]     i_s_axi_gmem_arid,
    input  logic [USER_WIDTH-1:0]   i_s_axi_gmem_aruser,
    input  logic                    i_s_axi_gmem_arlock,
    input  logic [3:0]              i_s_axi_gmem_arcache,
    input  logic [2:0]              i_s_axi_gmem_arprot,
    input  logic [3:0]              i_s_axi_gmem_arqos,
    input  logic [3:0]              i_s_axi_gmem_arregion,
    input  logic                    i_s_axi_gmem_arvalid,
    output logic                    o_s_axi_gmem_arready,
    output logic [DATA_WIDTH-1:0]   o_s_axi_gmem_rdata,
    output logic [1:0]              o_s_axi_gmem_rresp,
    output logic                    o_s_axi_gmem_rlast,
    output logic [ID_WIDTH-1:0]     o_s_axi_gmem_rid,
    output logic [USER_WIDTH-1:0]   o_s_axi_gmem_ruser,
    output logic                    o_s_axi_gmem_rvalid,
    input  logic                    i_s_axi_gmem_rready
);
    localparam int         BYTES   = DATA_WIDTH / 8;
    localparam int         SHIFT   = clog2(BYTES);
    localparam int         IDX_W   = MEM_DEPTH_LOG2;
    localparam int         DEPTH   = 1 << MEM_DEPTH_LOG2;
    localparam logic [2:0] SIZE_OK = 3'(SHIFT);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    rd_state_e r_rd_state, w_rd_state_nxt;
    wr_state_e r_wr_state, w_wr_state_nxt;

    logic                  w_stall;
    logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_ar_legal, w_aw_legal;
    logic [IDX_W-1:0]      w_ar_index, w_aw_index;
    logic [IDX_W-1:0]      w_rd_index, w_rd_next_index, w_wr_index, w_wr_next_index;
    logic [7:0]            w_rd_remaining, w_wr_remaining;
    logic                  w_rd_last, w_wr_last, w_rd_legal, w_wr_legal;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast, r_rvalid, r_werr;
    logic [ID_WIDTH-1:0]   r_rid, r_bid;
    logic                  w_unused;

`ifdef SDA_GMEM_SLAVE_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    assign w_ar_index = i_s_axi_gmem_araddr[IDX_W+SHIFT-1:SHIFT];
    assign w_aw_index = i_s_axi_gmem_awaddr[IDX_W+SHIFT-1:SHIFT];
    assign w_ar_legal = (i_s_axi_gmem_arburst == BURST_INCR) && (i_s_axi_gmem_arsize == SIZE_OK);
    assign w_aw_legal = (i_s_axi_gmem_awburst == BURST_INCR) && (i_s_axi_gmem_awsize == SIZE_OK);

    assign w_ar_hs = o_s_axi_gmem_arready & i_s_axi_gmem_arvalid;
    assign w_r_hs  = r_rvalid & i_s_axi_gmem_rready;
    assign w_aw_hs = o_s_axi_gmem_awready & i_s_axi_gmem_awvalid;
    assign w_w_hs  = o_s_axi_gmem_wready & i_s_axi_gmem_wvalid;
    assign w_b_hs  = o_s_axi_gmem_bvalid & i_s_axi_gmem_bready;

    sda_gmem_burst_addr #(.IDX_W(IDX_W)) u_rd_addr (
        .clk(clk), .reset(reset),
        .i_start(w_ar_hs), .i_index(w_ar_index), .i_len(i_s_axi_gmem_arlen), .i_legal(w_ar_legal),
        .i_step(w_r_hs && !w_rd_last),
        .o_index(w_rd_index), .o_next_index(w_rd_next_index), .o_remaining(w_rd_remaining),
        .o_last(w_rd_last), .o_legal(w_rd_legal)
    );

    sda_gmem_burst_addr #(.IDX_W(IDX_W)) u_wr_addr (
        .clk(clk), .reset(reset),
        .i_start(w_aw_hs), .i_index(w_aw_index), .i_len(i_s_axi_gmem_awlen), .i_legal(w_aw_legal),
        .i_step(w_w_hs && !w_wr_last),
        .o_index(w_wr_index), .o_next_index(w_wr_next_index), .o_remaining(w_wr_remaining),
        .o_last(w_wr_last), .o_legal(w_wr_legal)
    );

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (reset) r_rd_state <= RD_IDLE;
        else       r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs) w_rd_state_nxt = RD_DATA;
            RD_DATA: if (w_r_hs && w_rd_last) w_rd_state_nxt = RD_IDLE;
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        o_s_axi_gmem_arready = 1'b0;
        if (r_rd_state == RD_IDLE && !reset && !w_stall) o_s_axi_gmem_arready = 1'b1;
    end

    // Words are captured from the RAM at load time, so a same-cycle write is seen only by later loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rvalid <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata  <= w_ar_legal ? r_mem[w_ar_index] : '0;
            r_rresp  <= w_ar_legal ? RESP_OKAY : RESP_SLVERR;
            r_rlast  <= (i_s_axi_gmem_arlen == 8'd0);
            r_rid    <= i_s_axi_gmem_arid;
            r_rvalid <= 1'b1;
        end else if (w_r_hs && !w_rd_last) begin
            r_rdata  <= w_rd_legal ? r_mem[w_rd_next_index] : '0;
            r_rlast  <= (w_rd_remaining == 8'd1);
            r_rvalid <= !w_stall;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end else if (r_rd_state == RD_DATA && !r_rvalid && !w_stall) begin
            r_rvalid <= 1'b1;
        end
    end

    assign o_s_axi_gmem_rdata  = r_rdata;
    assign o_s_axi_gmem_rresp  = r_rresp;
    assign o_s_axi_gmem_rlast  = r_rlast;
    assign o_s_axi_gmem_rid    = r_rid;
    assign o_s_axi_gmem_ruser  = '0;
    assign o_s_axi_gmem_rvalid = r_rvalid;

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (reset) r_wr_state <= WR_IDLE;
        else       r_wr_state <= w_wr_state_nxt;
    end

    // The beat counter, not wlast, closes the burst.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_aw_hs) w_wr_state_nxt = WR_DATA;
            WR_DATA: if (w_w_hs && w_wr_last) w_wr_state_nxt = WR_RESP;
            WR_RESP: if (w_b_hs) w_wr_state_nxt = WR_IDLE;
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        o_s_axi_gmem_awready = 1'b0;
        o_s_axi_gmem_wready  = 1'b0;
        o_s_axi_gmem_bvalid  = 1'b0;
        o_s_axi_gmem_bresp   = RESP_OKAY;
        case (r_wr_state)
            WR_IDLE: o_s_axi_gmem_awready = !reset && !w_stall;
            WR_DATA: o_s_axi_gmem_wready  = !reset && !w_stall;
            WR_RESP: begin
                o_s_axi_gmem_bvalid = 1'b1;
                o_s_axi_gmem_bresp  = (!w_wr_legal || r_werr) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_werr <= 1'b0;
            r_bid  <= '0;
        end else if (w_aw_hs) begin
            r_werr <= 1'b0;
            r_bid  <= i_s_axi_gmem_awid;
        end else if (w_w_hs && (i_s_axi_gmem_wlast != w_wr_last)) begin
            r_werr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && w_wr_legal) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_s_axi_gmem_wstrb[b]) r_mem[w_wr_index][8*b +: 8] <= i_s_axi_gmem_wdata[8*b +: 8];
            end
        end
    end

    assign o_s_axi_gmem_bid   = r_bid;
    assign o_s_axi_gmem_buser = '0;

    assign w_unused = ^{i_s_axi_gmem_awaddr, i_s_axi_gmem_araddr, i_s_axi_gmem_awuser, i_s_axi_gmem_aruser,
                        i_s_axi_gmem_wuser, i_s_axi_gmem_awlock, i_s_axi_gmem_awcache, i_s_axi_gmem_awprot,
                        i_s_axi_gmem_awqos, i_s_axi_gmem_awregion, i_s_axi_gmem_arlock, i_s_axi_gmem_arcache,
                        i_s_axi_gmem_arprot, i_s_axi_gmem_arqos, i_s_axi_gmem_arregion, w_rd_index,
                        w_wr_next_index, w_wr_remaining};
endmodule
